pc_trace_tx: RTL

Execution-trace capture and UART streaming unit for the Monitor design. It samples committed (pc, inst) pairs from the CPU core while armed and buffers them in a parametrised FIFO. Each record is serialised over a UART 8N1 line, so the trace leaves the FPGA on the board's RsTx path. The number of records, the word width, the buffer depth and the baud divisor are configurable.

---
 rtl/pc_trace_tx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_trace_tx.sv
// pc_trace_tx: captures committed (pc, inst) pairs into a small FIFO while a
// capture window is open, and streams each record out as UART 8N1 bytes:
// SYNC_BYTE, pc (MSB first), inst (MSB first).
//
// Capture interface: cap_valid is a valid-only strobe with no ready. The core
// never stalls for tracing; a record that cannot be buffered is dropped and
// the sticky overflow flag records the loss.
module pc_trace_tx #(
    parameter int         DATA_W       = 32,
    parameter int         DEPTH        = 16,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic [15:0]       rec_limit,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_inst,
    output logic              tx,
    output logic              armed,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       rec_count,
    output logic [1:0]        fsm_state
);

    localparam int AW     = $clog2(DEPTH);
    localparam int RW     = 2 * DATA_W;
    localparam int NBYTES = 1 + DATA_W / 4;
    localparam int CW     = $clog2(CLKS_PER_BIT + 1);
    localparam int BW     = $clog2(NBYTES + 1);

    localparam logic [AW:0]   PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BYTE_ONE  = 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers (one extra wrap bit each)
    logic [RW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Capture window state
    logic [15:0]   limit_q;
    logic          win_open;
    logic [15:0]   limit_eff;
    logic [15:0]   count_base;
    logic [15:0]   count_inc;
    logic          hit_limit;
    logic          drop;

    // Transmitter state
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [BW-1:0] byte_idx;
    logic [BW-1:0] byte_idx_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic [RW-1:0] rec_q;
    logic [RW-1:0] rec_n;
    logic          tx_n;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy  = ~empty | (state != S_IDLE);
    assign fsm_state = state;

    // Capture decision: an arm in this cycle restarts the window before the
    // same-cycle record is considered, so that record becomes count 1.
    always_comb begin
        win_open   = arm | armed;
        limit_eff  = arm ? rec_limit : limit_q;
        count_base = arm ? 16'd0 : rec_count;
        count_inc  = (count_base == 16'hFFFF) ? count_base : count_base + 16'd1;
        hit_limit  = (limit_eff != 16'd0) && (count_inc == limit_eff);
        push       = win_open & cap_valid & (~full | pop);
        drop       = win_open & cap_valid & full & ~pop;
    end

    // Window control, record counter and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed     <= 1'b0;
            rec_count <= 16'd0;
            overflow  <= 1'b0;
            limit_q   <= 16'd0;
        end else begin
            if (arm) begin
                limit_q <= rec_limit;
            end
            if (push) begin
                rec_count <= count_inc;
                armed     <= ~hit_limit;
            end else begin
                rec_count <= count_base;
                armed     <= win_open;
            end
            overflow <= (overflow & ~arm) | drop;
        end
    end

    // FIFO pointers; a push and pop on a full FIFO both advance, staying full
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage write; the read side takes the old word on a same-slot pop
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cap_pc, cap_inst};
    end

    // TX next-state: bit timing, byte sequencing and the next line level
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        rec_n      = rec_q;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_n    = S_START;
                    clk_cnt_n  = '0;
                    byte_idx_n = '0;
                    shreg_n    = SYNC_BYTE;
                    rec_n      = mem[rd_ptr[AW-1:0]];
                end
            end
            S_START: begin
                if (clk_cnt == CNT_LAST) begin
                    state_n   = S_DATA;
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n    = S_START;
                        byte_idx_n = byte_idx + BYTE_ONE;
                        shreg_n    = rec_q[RW-1 -: 8];
                        rec_n      = {rec_q[RW-9:0], 8'h00};
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_ONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    // TX registers; tx is a flop preset by reset so it can never glitch low
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= '0;
            shreg    <= 8'hFF;
            rec_q    <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            shreg    <= shreg_n;
            rec_q    <= rec_n;
            tx       <= tx_n;
        end
    end

endmodule
